// File: rtl/fx3_packet_sequencer.sv
// fx3_packet_sequencer: paces ADC FIFO reads into fixed-size FX3 packets and
// produces a latency-matched data-valid strobe, completion pulse and sticky error flag.
module fx3_packet_sequencer #(
   parameter int PACKET_WORDS = 8192,
   parameter int PIPE_LATENCY = 2,
   parameter int GAP_CYCLES   = 4,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                 nReset,
   input  logic                 fx3_clock,
   input  logic                 collectData,
   input  logic                 dataAvailable,
   input  logic                 bufferError,
   input  logic                 fx3_bufferReady,
   output logic                 readData,
   output logic                 dataValid,
   output logic                 packetDone,
   output logic                 errorLatched,
   output logic                 busy,
   output logic [CNT_WIDTH-1:0] packetCount
);
   localparam int WW = $clog2(PACKET_WORDS);
   localparam int DW = $clog2((PIPE_LATENCY > GAP_CYCLES ? PIPE_LATENCY : GAP_CYCLES) + 1);
   localparam logic [WW-1:0] LAST_WORD  = WW'(PACKET_WORDS - 1);
   localparam logic [DW-1:0] LAST_DRAIN = DW'(PIPE_LATENCY - 1);
   localparam logic [DW-1:0] LAST_GAP   = DW'(GAP_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, STREAM, DRAIN, GAP, ERROR} state_t;

   state_t                  state;
   logic [WW-1:0]           word_cnt;
   logic [DW-1:0]           wait_cnt;
   logic [PIPE_LATENCY-1:0] valid_pipe;
   logic                    restart;
   logic                    fault;

   // Reads stop the same cycle the FX3 stalls, so the gate stays combinational.
   assign readData  = (state == STREAM) && fx3_bufferReady;
   assign dataValid = valid_pipe[PIPE_LATENCY-1];
   assign fault     = collectData && bufferError && (state != ERROR);

   always_ff @(posedge fx3_clock or negedge nReset) begin
      if (!nReset)
         valid_pipe <= '0;
      else
         valid_pipe <= (valid_pipe << 1) | PIPE_LATENCY'(readData);
   end

   always_ff @(posedge fx3_clock or negedge nReset) begin
      if (!nReset) begin
         state        <= IDLE;
         word_cnt     <= '0;
         wait_cnt     <= '0;
         restart      <= 1'b0;
         packetDone   <= 1'b0;
         errorLatched <= 1'b0;
         busy         <= 1'b0;
         packetCount  <= '0;
      end else begin
         packetDone <= 1'b0;
         if (fault) begin
            state        <= ERROR;
            word_cnt     <= '0;
            wait_cnt     <= '0;
            errorLatched <= 1'b1;
            busy         <= 1'b1;
         end else begin
            case (state)
               IDLE: begin
                  if (!collectData)
                     restart <= 1'b1;
                  else if (dataAvailable && fx3_bufferReady) begin
                     state   <= STREAM;
                     busy    <= 1'b1;
                     restart <= 1'b0;
                     if (restart) packetCount <= '0;
                  end
               end
               STREAM: begin
                  if (readData) begin
                     word_cnt <= word_cnt + WW'(1);
                     if (word_cnt == LAST_WORD) state <= DRAIN;
                  end
               end
               DRAIN: begin
                  wait_cnt <= wait_cnt + DW'(1);
                  if (wait_cnt == LAST_DRAIN) begin
                     state       <= GAP;
                     wait_cnt    <= '0;
                     packetDone  <= 1'b1;
                     packetCount <= packetCount + CNT_WIDTH'(1);
                  end
               end
               GAP: begin
                  wait_cnt <= wait_cnt + DW'(1);
                  if (wait_cnt == LAST_GAP) begin
                     state    <= IDLE;
                     wait_cnt <= '0;
                     busy     <= 1'b0;
                  end
               end
               ERROR: begin
                  if (!collectData) begin
                     state        <= IDLE;
                     errorLatched <= 1'b0;
                     busy         <= 1'b0;
                     restart      <= 1'b1;
                  end
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_fx3_packet_sequencer.sv
// tb_fx3_packet_sequencer: directed scenarios with randomized stalls/error points,
// checked every cycle against a cycle-arithmetic reference model.
module tb_fx3_packet_sequencer;
   localparam int PW = 8192;
   localparam int PL = 2;
   localparam int GC = 4;
   localparam int CW = 16;

   logic          nReset = 0, fx3_clock = 0;
   logic          collectData = 0, dataAvailable = 0, bufferError = 0, fx3_bufferReady = 0;
   logic          readData, dataValid, packetDone, errorLatched, busy;
   logic [CW-1:0] packetCount;

   int tests = 0, failed = 0, cyc = 0;
   int m_left, m_idle_at, m_done_at, m_count;
   bit m_err, m_restart;
   bit vq[$];
   int rd_cnt, dv_cnt, done_cnt, pkt_rd, last_rd, min_gap;

   fx3_packet_sequencer #(
      .PACKET_WORDS(PW), .PIPE_LATENCY(PL), .GAP_CYCLES(GC), .CNT_WIDTH(CW)
   ) dut (
      .nReset(nReset), .fx3_clock(fx3_clock), .collectData(collectData),
      .dataAvailable(dataAvailable), .bufferError(bufferError),
      .fx3_bufferReady(fx3_bufferReady), .readData(readData), .dataValid(dataValid),
      .packetDone(packetDone), .errorLatched(errorLatched), .busy(busy),
      .packetCount(packetCount)
   );

   always #5 fx3_clock = ~fx3_clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_left = 0; m_idle_at = 0; m_done_at = -1; m_count = 0;
      m_err = 0; m_restart = 0;
      vq.delete();
      for (int i = 0; i < PL; i++) vq.push_back(1'b0);
   endtask

   task automatic clr();
      rd_cnt = 0; dv_cnt = 0; done_cnt = 0; pkt_rd = 0; last_rd = -1; min_gap = 1 << 30;
   endtask

   // Model advance at a rising edge; cyc is the cycle that just ended.
   task automatic model_edge(input bit er);
      vq.push_back(er);
      vq.delete(0);
      if (!nReset) m_reset();
      else if (!m_err && collectData && bufferError) begin
         m_err = 1; m_left = 0; m_done_at = -1;
      end else if (m_err) begin
         if (!collectData) begin m_err = 0; m_restart = 1; m_idle_at = cyc + 1; end
      end else if (m_left > 0) begin
         if (er) begin
            m_left--;
            if (m_left == 0) begin m_done_at = cyc + PL + 1; m_idle_at = cyc + PL + GC + 1; end
         end
      end else if (cyc < m_idle_at) begin
         if (cyc + 1 == m_done_at) m_count++;
      end else if (!collectData)
         m_restart = 1;
      else if (dataAvailable && fx3_bufferReady) begin
         m_left = PW;
         if (m_restart) begin m_count = 0; m_restart = 0; end
      end
   endtask

   // Called just after a falling edge with this cycle's inputs already driven.
   task automatic cyc_step();
      bit er;
      er = !m_err && m_left > 0 && fx3_bufferReady;
      #1;
      chk("readData", 32'(readData), 32'(er));
      chk("dataValid", 32'(dataValid), 32'(vq[0]));
      chk("packetDone", 32'(packetDone), 32'(cyc == m_done_at));
      chk("errorLatched", 32'(errorLatched), 32'(m_err));
      chk("busy", 32'(busy), 32'(m_err || m_left > 0 || cyc < m_idle_at));
      chk("packetCount", 32'(packetCount), 32'(m_count % (1 << CW)));
      if (readData) begin
         if (pkt_rd == 0 && last_rd >= 0 && cyc - last_rd - 1 < min_gap) min_gap = cyc - last_rd - 1;
         pkt_rd++; rd_cnt++; last_rd = cyc;
      end
      if (dataValid) dv_cnt++;
      if (packetDone) begin done_cnt++; pkt_rd = 0; end
      @(posedge fx3_clock);
      model_edge(er);
      cyc++;
      @(negedge fx3_clock);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: bench did not reach its end");
      $fatal(1, "watchdog");
   end

   initial begin
      int stall_at, r0, r1, d0, d1, err_w;
      m_reset();
      clr();
      @(negedge fx3_clock);
      repeat (3) cyc_step();
      nReset = 1;

      // single packet, FX3 always ready
      clr(); collectData = 1; dataAvailable = 1; fx3_bufferReady = 1;
      for (int i = 0; i < PW + 20; i++) begin
         cyc_step();
         if (done_cnt > 0) dataAvailable = 0;
      end
      chk("t1_reads", rd_cnt, PW);
      chk("t1_valid", dv_cnt, PW);
      chk("t1_done", done_cnt, 1);
      chk("t1_count", 32'(packetCount), 1);

      // random stalls plus a forced 100-cycle stall after 4000 reads
      clr(); dataAvailable = 1; stall_at = -1; r0 = 0; r1 = 0; d0 = 0; d1 = 0;
      for (int i = 0; i < 3 * PW && done_cnt == 0; i++) begin
         if (stall_at < 0 && rd_cnt == 4000) stall_at = cyc;
         if (stall_at >= 0 && cyc == stall_at) r0 = rd_cnt;
         if (stall_at >= 0 && cyc == stall_at + 100) r1 = rd_cnt;
         if (stall_at >= 0 && cyc == stall_at + PL) d0 = dv_cnt;
         if (stall_at >= 0 && cyc == stall_at + PL + 100) d1 = dv_cnt;
         fx3_bufferReady = (stall_at >= 0 && cyc < stall_at + 100) ? 1'b0 : 1'($urandom_range(0, 7) != 0);
         cyc_step();
      end
      dataAvailable = 0; fx3_bufferReady = 1;
      repeat (12) cyc_step();
      chk("t2_stall_seen", 32'(stall_at >= 0), 1);
      chk("t2_stall_reads", r1 - r0, 0);
      chk("t2_stall_valid", d1 - d0, 0);
      chk("t2_reads", rd_cnt, PW);
      chk("t2_valid", dv_cnt, PW);
      chk("t2_done", done_cnt, 1);
      chk("t2_count", 32'(packetCount), 2);

      // new capture, three back-to-back packets
      clr(); collectData = 0; repeat (3) cyc_step();
      collectData = 1; dataAvailable = 1;
      for (int i = 0; i < 3 * (PW + 20) && done_cnt < 3; i++) cyc_step();
      dataAvailable = 0;
      repeat (12) cyc_step();
      chk("t3_done", done_cnt, 3);
      chk("t3_reads", rd_cnt, 3 * PW);
      chk("t3_count", 32'(packetCount), 3);
      chk("t3_gap_ok", 32'(min_gap >= PL + GC + 1), 1);

      // error pulse mid-packet
      clr(); err_w = 4500 + int'($urandom_range(0, 1000)); dataAvailable = 1;
      for (int i = 0; i < 3 * PW && rd_cnt < err_w; i++) begin
         fx3_bufferReady = 1'($urandom_range(0, 3) != 0);
         cyc_step();
      end
      bufferError = 1; dataAvailable = 0;
      cyc_step();
      bufferError = 0; fx3_bufferReady = 1; r0 = rd_cnt;
      repeat (20) cyc_step();
      chk("t4_reached", 32'(r0 >= err_w), 1);
      chk("t4_reads_after", rd_cnt - r0, 0);
      chk("t4_err", 32'(errorLatched), 1);
      chk("t4_busy", 32'(busy), 1);
      chk("t4_done", done_cnt, 0);
      chk("t4_drain", dv_cnt, rd_cnt);
      collectData = 0;
      repeat (3) cyc_step();
      chk("t4_err_clr", 32'(errorLatched), 0);
      chk("t4_idle", 32'(busy), 0);

      // collectData dropped after 100 reads
      clr(); collectData = 1; dataAvailable = 1; fx3_bufferReady = 1;
      for (int i = 0; i < PW + 40; i++) begin
         if (rd_cnt == 100) collectData = 0;
         cyc_step();
      end
      chk("t5_reads", rd_cnt, PW);
      chk("t5_done", done_cnt, 1);
      chk("t5_count", 32'(packetCount), 1);
      chk("t5_idle", 32'(busy), 0);

      // asynchronous reset after 3000 reads
      clr(); collectData = 1; dataAvailable = 1; fx3_bufferReady = 1;
      for (int i = 0; i < PW && rd_cnt < 3000; i++) cyc_step();
      #2 nReset = 0;
      #1;
      chk("rst_readData", 32'(readData), 0);
      chk("rst_dataValid", 32'(dataValid), 0);
      chk("rst_packetDone", 32'(packetDone), 0);
      chk("rst_errorLatched", 32'(errorLatched), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_packetCount", 32'(packetCount), 0);
      m_reset();
      @(negedge fx3_clock);
      cyc++;
      repeat (2) cyc_step();
      nReset = 1;
      clr();
      for (int i = 0; i < PW + 20; i++) begin
         cyc_step();
         if (done_cnt > 0) dataAvailable = 0;
      end
      chk("t6_reads", rd_cnt, PW);
      chk("t6_valid", dv_cnt, PW);
      chk("t6_done", done_cnt, 1);
      chk("t6_count", 32'(packetCount), 1);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule

// File: doc/fx3_packet_sequencer.md
Name: fx3_packet_sequencer

Overview:
Controls the read side of the ADC sample FIFO in the fx3_clock domain. It waits until a full packet is buffered and the FX3 has a DMA buffer free, then issues exactly PACKET_WORDS FIFO read requests. It produces a data-valid strobe aligned with the 16-bit output bus and reports packet completion and error status to the FX3 interface. It sits between the data generator (FIFO, 10→16-bit converter) and the FX3 GPIF pins.

Parameters:
PACKET_WORDS, 8192, words per USB packet (power of two, ≥4)
PIPE_LATENCY, 2, fx3_clock cycles from readData high to the matching word on dataOut (FIFO q register + converter register)
GAP_CYCLES, 4, idle cycles after a packet before dataAvailable is re-sampled (FIFO rdusedw update latency)
CNT_WIDTH, 16, width of packetCount

Ports:
nReset  in  1  asynchronous reset, active-low
fx3_clock  in  1  FX3 clock; all logic on rising edge
collectData  in  1  capture enabled (already synchronous to fx3_clock)
dataAvailable  in  1  FIFO holds ≥ PACKET_WORDS words
bufferError  in  1  FIFO overflow/near-full flag from data generator
fx3_bufferReady  in  1  FX3 DMA buffer can accept words; may drop mid-packet
readData  out  1  FIFO read request
dataValid  out  1  dataOut carries a valid packet word this cycle
packetDone  out  1  one-cycle pulse in the cycle after the last valid word of a packet
errorLatched  out  1  sticky error flag for FX3
busy  out  1  high whenever state ≠ IDLE
packetCount  out  CNT_WIDTH  completed packets since capture start

Behaviour:
- Reset (async, nReset low): state IDLE; readData, dataValid, packetDone, errorLatched, busy = 0; packetCount = 0; word counter and valid delay line = 0.
- States: IDLE, STREAM, DRAIN, GAP, ERROR.
- IDLE: if collectData && bufferError → ERROR. Else if collectData && dataAvailable && fx3_bufferReady → STREAM; readData goes high in the first STREAM cycle.
- STREAM: readData = fx3_bufferReady (combinational gate off the registered state; no read while FX3 stalls). The word counter increments on each readData cycle. When readData is high with counter = PACKET_WORDS-1 → DRAIN. Exactly PACKET_WORDS reads per packet regardless of stalls.
- DRAIN: readData = 0; hold for PIPE_LATENCY cycles so the last words emerge. packetDone pulses in the cycle after the final dataValid; packetCount increments on the same edge (wraps at 2^CNT_WIDTH). Then → GAP.
- GAP: GAP_CYCLES cycles with readData = 0, then → IDLE. Back-to-back packets are therefore separated by ≥ PIPE_LATENCY+GAP_CYCLES+1 idle cycles.
- dataValid = readData delayed by exactly PIPE_LATENCY cycles through a shift register, independent of state. The total dataValid count per packet is exactly PACKET_WORDS.
- Error: bufferError sampled high while collectData is high in any state except ERROR → ERROR on the next edge. readData is forced 0 immediately in ERROR; in-flight dataValid words still drain; no packetDone for a truncated packet. errorLatched = 1 in ERROR. ERROR exits to IDLE only when collectData = 0; errorLatched clears on that exit.
- collectData falling mid-packet: the packet completes normally (the FIFO already holds ≥ PACKET_WORDS words), then the block returns to IDLE and stays there.
- packetCount clears to 0 on the IDLE→STREAM transition when the previous capture ended (collectData was low in IDLE). It holds its value while collectData stays high.
- dataAvailable is ignored outside IDLE. fx3_bufferReady is ignored outside IDLE/STREAM.
- busy = (state ≠ IDLE).

Test Plan:
- Single packet: collectData=1, dataAvailable=1, fx3_bufferReady=1 from cycle 0 → readData high 8192 consecutive cycles; dataValid high 8192 cycles starting 2 cycles later; packetDone one pulse; packetCount=1.
- FX3 stall: drop fx3_bufferReady for 100 cycles at word 4000 → readData low for exactly those cycles, total reads still 8192, dataValid gap matches shifted by 2.
- Back-to-back: dataAvailable held 1 for 3 packets → packetCount=3; gap between the last read of one packet and the first read of the next ≥ 7 cycles.
- Error mid-packet: bufferError pulse at word 5000 → readData 0 next cycle, errorLatched=1, no packetDone; clear collectData → IDLE and errorLatched=0.
- collectData dropped at word 100 → packet completes with 8192 reads and packetDone, then stays IDLE even though dataAvailable=1.
- Async reset asserted at word 3000 → all outputs 0 immediately without a clock edge; after release with dataAvailable=1, a full 8192-word packet runs with packetCount=1.
